aes_stream_cipher: RTL and testbench
====================================

Name: aes_stream_cipher

Overview:
- Byte-serial, counter-mode (CTR) stream cipher: each input byte is XORed with a keystream byte.
- Keystream byte = AES forward S-box applied to (message counter XOR latched 8-bit key).
- Sits in the datapath between a byte-wide source and sink; one byte per clock, with a fixed one-cycle registered latency.
- Encryption and decryption are the same operation.

Parameters:
- None. Data, key and counter widths are fixed at 8 bits.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- valid_in  input  1  data_in holds a valid byte this cycle.
- new_message  input  1  qualified by valid_in; this byte is the first byte of a new message.
- key  input  8  cipher key; sampled only on the first byte of a message.
- data_in  input  8  plaintext (or ciphertext) byte.
- data_out  output  8  registered result byte.
- valid_out  output  1  registered; data_out is valid this cycle.

Behaviour:
- Reset (reset_n low, asynchronous): data_out=0x00, valid_out=0, key_reg=0x00, ctr=0x00. All registers hold these values while reset_n is low.
- S-box: standard FIPS-197 AES forward S-box, 256-entry combinational lookup (e.g. S(0x00)=0x63, S(0x01)=0x7c, S(0x2b)=0xf1).
- Effective key and counter (combinational) when valid_in=1 and new_message=1:
  - k_eff = key, c_eff = 0x00.
  - On that clock edge: key_reg <= key, ctr <= 0x01.
- Effective key and counter when valid_in=1 and new_message=0:
  - k_eff = key_reg, c_eff = ctr.
  - On that clock edge: ctr <= ctr+1, modulo 256 (0xff wraps to 0x00).
- Output on every edge where valid_in=1:
  - data_out <= data_in XOR S(c_eff XOR k_eff).
  - valid_out <= 1.
- Idle cycle (valid_in=0):
  - valid_out <= 0.
  - data_out, ctr and key_reg hold their values.
  - new_message is ignored.
- Latency: exactly 1 clock. The input sampled at edge N appears at data_out/valid_out after edge N. Back-to-back throughput is 1 byte per clock; there is no backpressure.
- Gaps inside a message (valid_in low) do not advance ctr. The message resumes at the next counter value.
- new_message asserted mid-stream restarts the message: ctr is reloaded and the key is re-latched in that same cycle, with no bubble.
- key changes while new_message=0 have no effect.
- A byte sent before any new_message since reset uses key_reg=0x00 and the current ctr.
- Reset asserted mid-message:
  - valid_out drops immediately (asynchronously).
  - The next message must restart with new_message; without it, ctr=0 and key_reg=0 are used.

Test Plan:
- Reset check: hold reset_n low with valid_in=1 -> valid_out=0 and data_out=0x00 throughout; no output appears until after the first edge following reset release.
- Basic stream: key=0x00, data_in=0x00 for 4 consecutive cycles, new_message=1 on the first only -> data_out = 0x63, 0x7c, 0x77, 0x7b on consecutive cycles, each one cycle after its input, with valid_out=1.
- Key latch: key=0x2b, new_message=1, data_in=0x00 -> data_out=0xf1. Then change key to 0xff with new_message=0, data_in=0x00 -> data_out=S(0x01^0x2b)=S(0x2a)=0xe5, showing the key change is ignored.
- Gaps and restart: drop valid_in mid-message -> valid_out=0, ctr holds, and the stream resumes with the next keystream byte. Assert new_message on a later byte -> keystream restarts at S(key).
- Wrap-around and round-trip: send 257 bytes in one message -> byte 257 uses ctr=0x00 again (same keystream as byte 1). Feed the output back through with the same key -> the original plaintext is recovered.

Source files
------------

// File: rtl/aes_stream_cipher_if.sv
// ----------------------------------------------------------------------------
// aes_stream_cipher_if
//
// Byte-stream bundle between a data source/sink and aes_stream_cipher.
//
// Signals:
//   valid_in     source -> cipher  data_in holds a valid byte this cycle
//   new_message  source -> cipher  byte is the first of a new message
//   key          source -> cipher  cipher key, sampled on first byte only
//   data_in      source -> cipher  plaintext or ciphertext byte
//   data_out     cipher -> sink    registered result byte
//   valid_out    cipher -> sink    data_out is valid this cycle
//
// Modports:
//   master  the source/sink side (drives the input byte stream)
//   slave   the cipher side
// ----------------------------------------------------------------------------
interface aes_stream_cipher_if;
    logic       valid_in;
    logic       new_message;
    logic [7:0] key;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       valid_out;

    modport master (
        output valid_in,
        output new_message,
        output key,
        output data_in,
        input  data_out,
        input  valid_out
    );

    modport slave (
        input  valid_in,
        input  new_message,
        input  key,
        input  data_in,
        output data_out,
        output valid_out
    );
endinterface

// File: rtl/aes_stream_cipher.sv
// ----------------------------------------------------------------------------
// aes_stream_cipher
//
// Byte-serial counter-mode stream cipher. Each valid input byte is XORed with
// keystream byte S(ctr ^ key), where S is the AES forward S-box. Encryption
// and decryption are the same operation. One byte per clock, one cycle of
// registered latency, no backpressure.
//
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      aes_stream_cipher_if.slave (valid_in, new_message, key, data_in,
//            data_out, valid_out)
// ----------------------------------------------------------------------------
module aes_stream_cipher (
    input  logic                      clk,
    input  logic                      reset_n,
    aes_stream_cipher_if.slave        bus
);

    // AES forward S-box, index 0x00 first.
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    logic [7:0] key_q, key_d;
    logic [7:0] ctr_q, ctr_d;
    logic [7:0] data_out_q, data_out_d;
    logic       valid_out_q;

    logic [7:0] k_eff;
    logic [7:0] c_eff;
    logic [7:0] keystream;

    // A first byte uses the incoming key and counter 0 directly, so a restart
    // takes effect in the same cycle with no bubble.
    always_comb begin
        k_eff      = key_q;
        c_eff      = ctr_q;
        key_d      = key_q;
        ctr_d      = ctr_q;
        data_out_d = data_out_q;

        if (bus.valid_in) begin
            if (bus.new_message) begin
                k_eff = bus.key;
                c_eff = 8'h00;
                key_d = bus.key;
                ctr_d = 8'h01;
            end else begin
                ctr_d = ctr_q + 8'h01;
            end
        end

        keystream = SBOX[c_eff ^ k_eff];

        if (bus.valid_in) begin
            data_out_d = bus.data_in ^ keystream;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_q       <= 8'h00;
            ctr_q       <= 8'h00;
            data_out_q  <= 8'h00;
            valid_out_q <= 1'b0;
        end else begin
            key_q       <= key_d;
            ctr_q       <= ctr_d;
            data_out_q  <= data_out_d;
            valid_out_q <= bus.valid_in;
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.valid_out = valid_out_q;

endmodule

// File: tb/tb_aes_stream_cipher.sv
// ----------------------------------------------------------------------------
// tb_aes_stream_cipher
//
// Directed self-checking bench for aes_stream_cipher. Inputs change 1 ns after
// each rising edge; outputs are sampled at that same point, before the next
// byte is applied.
// ----------------------------------------------------------------------------
module tb_aes_stream_cipher;

    logic clk;
    logic reset_n;

    aes_stream_cipher_if bus ();

    aes_stream_cipher dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] p [257];
    logic [7:0] c [257];

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp_v);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp_v);
        end
    endtask

    task automatic check(input string tag, input logic exp_valid, input logic [7:0] exp_data);
        check_bit({tag, ".valid"}, bus.valid_out, exp_valid);
        check_eq({tag, ".data"}, bus.data_out, exp_data);
    endtask

    // Apply one cycle of inputs, then advance to 1 ns after the next edge.
    task automatic cycle(input logic v, input logic nm, input logic [7:0] k, input logic [7:0] d);
        bus.valid_in    = v;
        bus.new_message = nm;
        bus.key         = k;
        bus.data_in     = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;

        // Held in reset with valid traffic presented: outputs stay cleared.
        cycle(1'b1, 1'b1, 8'h2b, 8'h55);
        check("rst0", 1'b0, 8'h00);
        cycle(1'b1, 1'b1, 8'h2b, 8'h55);
        check("rst1", 1'b0, 8'h00);
        cycle(1'b1, 1'b1, 8'h2b, 8'h55);
        check("rst2", 1'b0, 8'h00);

        // Release between edges: nothing appears before the next edge.
        #2 reset_n = 1'b1;
        #1 check("rst_rel", 1'b0, 8'h00);
        cycle(1'b1, 1'b1, 8'h2b, 8'h55);
        check("first", 1'b1, 8'ha4);        // 0x55 ^ S(0x2b)=0xf1

        // Basic stream, key 0x00.
        cycle(1'b1, 1'b1, 8'h00, 8'h00);
        check("basic0", 1'b1, 8'h63);
        cycle(1'b1, 1'b0, 8'h00, 8'h00);
        check("basic1", 1'b1, 8'h7c);
        cycle(1'b1, 1'b0, 8'h00, 8'h00);
        check("basic2", 1'b1, 8'h77);
        cycle(1'b1, 1'b0, 8'h00, 8'h00);
        check("basic3", 1'b1, 8'h7b);

        // Key latched on first byte only.
        cycle(1'b1, 1'b1, 8'h2b, 8'h00);
        check("klatch0", 1'b1, 8'hf1);
        cycle(1'b1, 1'b0, 8'hff, 8'h00);
        check("klatch1", 1'b1, 8'he5);      // S(0x01^0x2b)
        cycle(1'b1, 1'b0, 8'hff, 8'h00);
        check("klatch2", 1'b1, 8'ha5);      // S(0x02^0x2b)

        // Gap: valid drops, data holds, counter frozen.
        cycle(1'b0, 1'b0, 8'h00, 8'hee);
        check("gap0", 1'b0, 8'ha5);
        cycle(1'b0, 1'b0, 8'h00, 8'hee);
        check("gap1", 1'b0, 8'ha5);
        cycle(1'b1, 1'b0, 8'h00, 8'h10);
        check("resume", 1'b1, 8'h24);       // 0x10 ^ S(0x03^0x2b)=0x34
        cycle(1'b0, 1'b1, 8'h99, 8'h00);    // new_message ignored when idle
        check("gap_nm", 1'b0, 8'h24);
        cycle(1'b1, 1'b0, 8'h00, 8'h00);
        check("resume2", 1'b1, 8'h15);      // S(0x04^0x2b)

        // Restart mid-stream, no bubble.
        cycle(1'b1, 1'b1, 8'h01, 8'h00);
        check("restart0", 1'b1, 8'h7c);     // S(0x01)
        cycle(1'b1, 1'b0, 8'h00, 8'h00);
        check("restart1", 1'b1, 8'h63);     // S(0x01^0x01)

        // Asynchronous reset mid-message.
        #2 reset_n = 1'b0;
        #1 check("async_rst", 1'b0, 8'h00);
        #2 reset_n = 1'b1;
        cycle(1'b1, 1'b0, 8'h77, 8'h00);
        check("post_rst0", 1'b1, 8'h63);    // key_reg=0, ctr=0
        cycle(1'b1, 1'b0, 8'h77, 8'h00);
        check("post_rst1", 1'b1, 8'h7c);

        // 257-byte message: counter wraps to 0x00 on the last byte.
        for (int i = 0; i < 257; i++) begin
            p[i] = 8'(i * 7 + 3);
        end
        for (int i = 0; i < 257; i++) begin
            cycle(1'b1, (i == 0), 8'h3c, p[i]);
            c[i] = bus.data_out;
            if (i == 0 || i == 256) begin
                check_bit("enc_valid", bus.valid_out, 1'b1);
            end
        end
        check_eq("ks_first", c[0] ^ p[0], 8'heb);       // S(0x3c)
        check_eq("ks_second", c[1] ^ p[1], 8'h27);      // S(0x3d)
        check_eq("ks_wrap", c[256] ^ p[256], 8'heb);    // ctr back to 0x00

        // Round trip: decrypting the ciphertext with the same key.
        for (int i = 0; i < 257; i++) begin
            cycle(1'b1, (i == 0), 8'h3c, c[i]);
            check($sformatf("dec%0d", i), 1'b1, p[i]);
        end

        cycle(1'b0, 1'b0, 8'h00, 8'h00);
        check_bit("end_idle", bus.valid_out, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
